execute_muldiv_seq: RTL and testbench

//   Iterative multiply/divide sequencer for the execute stage; produces the data_mul/data_div results.

---
 rtl/execute_muldiv_seq_pkg.sv | 13 +
 rtl/execute_muldiv_seq_step.sv | 41 ++++
 rtl/execute_muldiv_seq.sv | 122 ++++++++++++
 tb/tb_execute_muldiv_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/execute_muldiv_seq_pkg.sv
// Shared opcode constants and sequencer state encoding for the iterative mul/div unit.
package execute_muldiv_seq_pkg;

    localparam logic [6:0] OP_MUL = 7'b000_0010;
    localparam logic [6:0] OP_DIV = 7'b000_0011;

    typedef enum logic [1:0] {
        MDS_IDLE = 2'd0,
        MDS_RUN  = 2'd1,
        MDS_DONE = 2'd2
    } mds_state_e;

endpackage

// File: rtl/execute_muldiv_seq_step.sv
// One combinational iteration: shift-add multiply (LSB-first) or restoring divide (MSB-first).
// acc is the partial product / remainder; opa is multiplicand / dividend-quotient; opb is multiplier / divisor.
module execute_muldiv_seq_step #(
    parameter int LEN_REG = 32
) (
    input  logic               op_div_i,
    input  logic [LEN_REG:0]   acc_i,
    input  logic [LEN_REG-1:0] opa_i,
    input  logic [LEN_REG-1:0] opb_i,
    output logic [LEN_REG:0]   acc_o,
    output logic [LEN_REG-1:0] opa_o,
    output logic [LEN_REG-1:0] opb_o
);

    logic [LEN_REG-1:0] mul_sum;
    logic [LEN_REG+1:0] trial;

    assign mul_sum = acc_i[LEN_REG-1:0] + (opb_i[0] ? opa_i : '0);
    // Remainder shifted left with the next dividend bit, minus the divisor; MSB is the borrow.
    assign trial   = {acc_i, opa_i[LEN_REG-1]} - {2'b00, opb_i};

    always_comb begin
        acc_o = acc_i;
        opa_o = opa_i;
        opb_o = opb_i;
        if (op_div_i) begin
            if (trial[LEN_REG+1]) begin
                acc_o = {acc_i[LEN_REG-1:0], opa_i[LEN_REG-1]};
                opa_o = {opa_i[LEN_REG-2:0], 1'b0};
            end else begin
                acc_o = trial[LEN_REG:0];
                opa_o = {opa_i[LEN_REG-2:0], 1'b1};
            end
        end else begin
            acc_o = {1'b0, mul_sum};
            opa_o = opa_i << 1;
            opb_o = opb_i >> 1;
        end
    end

endmodule

// File: rtl/execute_muldiv_seq.sv
// Iterative mul/div sequencer: result valid LEN_REG clocks after accept; result held while stall_i.
// Upstream is stalled while running and while a finished result is blocked downstream.
module execute_muldiv_seq
    import execute_muldiv_seq_pkg::*;
#(
    parameter int LEN_REG     = 32,
    parameter int LEN_OPECODE = 7,
    parameter int LEN_CNT     = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    output logic                   stall_o,
    output logic                   valid_o,
    input  logic                   stall_i,
    input  logic [LEN_OPECODE-1:0] opecode,
    input  logic [LEN_REG-1:0]     data_rd,
    input  logic [LEN_REG-1:0]     data_rs,
    output logic [LEN_REG-1:0]     data_o,
    output logic                   busy
);

    localparam logic [LEN_CNT-1:0] LAST_STEP = LEN_CNT'(LEN_REG - 1);

    mds_state_e         state_q, state_d;
    logic [LEN_CNT-1:0] cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic [LEN_REG:0]   acc_q, acc_d;
    logic [LEN_REG-1:0] opa_q, opa_d;
    logic [LEN_REG-1:0] opb_q, opb_d;
    logic [LEN_REG-1:0] data_q, data_d;
    logic               valid_q, valid_d;

    logic               is_mul_op, is_div_op, accept;
    logic [LEN_REG:0]   step_acc;
    logic [LEN_REG-1:0] step_opa, step_opb;

    execute_muldiv_seq_step #(.LEN_REG(LEN_REG)) u_step (
        .op_div_i (is_div_q),
        .acc_i    (acc_q),
        .opa_i    (opa_q),
        .opb_i    (opb_q),
        .acc_o    (step_acc),
        .opa_o    (step_opa),
        .opb_o    (step_opb)
    );

    assign is_mul_op = (opecode == LEN_OPECODE'(OP_MUL));
    assign is_div_op = (opecode == LEN_OPECODE'(OP_DIV));
    assign accept    = valid_i & (is_mul_op | is_div_op) &
                       ((state_q == MDS_IDLE) | ((state_q == MDS_DONE) & ~stall_i));

    assign stall_o = (state_q == MDS_RUN) | ((state_q == MDS_DONE) & stall_i);
    assign busy    = (state_q != MDS_IDLE);
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        data_d   = data_q;
        valid_d  = valid_q;
        case (state_q)
            MDS_IDLE: ;
            MDS_RUN: begin
                acc_d = step_acc;
                opa_d = step_opa;
                opb_d = step_opb;
                cnt_d = cnt_q + LEN_CNT'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = MDS_DONE;
                    data_d  = is_div_q ? step_opa : step_acc[LEN_REG-1:0];
                    valid_d = 1'b1;
                end
            end
            MDS_DONE: begin
                if (!stall_i) begin
                    state_d = MDS_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = MDS_IDLE;
        endcase
        // Accept overrides DONE's consume so back-to-back ops skip IDLE.
        if (accept) begin
            state_d  = MDS_RUN;
            cnt_d    = '0;
            is_div_d = is_div_op;
            acc_d    = '0;
            opa_d    = data_rd;
            opb_d    = data_rs;
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= MDS_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_execute_muldiv_seq.sv
// Randomised bench for execute_muldiv_seq against a plain-arithmetic reference.
module tb_execute_muldiv_seq;

    localparam logic [6:0] OPC_ADD = 7'b000_0000;
    localparam logic [6:0] OPC_MUL = 7'b000_0010;
    localparam logic [6:0] OPC_DIV = 7'b000_0011;
    localparam int         LAT     = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, stall_o, valid_o, stall_i, busy;
    logic [6:0]  opecode;
    logic [31:0] data_rd, data_rs, data_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    execute_muldiv_seq dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .stall_o (stall_o),
        .valid_o (valid_o),
        .stall_i (stall_i),
        .opecode (opecode),
        .data_rd (data_rd),
        .data_rs (data_rs),
        .data_o  (data_o),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic is_div, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] prod;
        if (is_div)
            return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
        prod = 64'(a) * 64'(b);
        return prod[31:0];
    endfunction

    // Issues one op, scrambles the inputs after accept, waits (bounded) for the result.
    task automatic do_op(input logic [6:0] opc, input logic [31:0] a, input logic [31:0] b);
        int          n;
        int          stalls;
        logic [31:0] expv;
        expv = ref_result(opc == OPC_DIV, a, b);
        @(negedge clk);
        valid_i = 1'b1;
        opecode = opc;
        data_rd = a;
        data_rs = b;
        #1;
        chk("stall_pre", 64'(stall_o), 64'(0));
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        data_rd = $urandom;
        data_rs = $urandom;
        n = 0;
        stalls = 0;
        while (!valid_o && n < LAT + 8) begin
            if (stall_o) stalls++;
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 64'(n), 64'(LAT));
        chk("stall_cycles", 64'(stalls), 64'(LAT));
        chk("result", 64'(data_o), 64'(expv));
    endtask

    task automatic consume();
        @(posedge clk);
        #1;
        chk("valid_drop", 64'(valid_o), 64'(0));
        chk("idle_after", 64'(busy), 64'(0));
    endtask

    initial begin
        logic [31:0] ra, rb, rexp;
        logic [6:0]  ropc;
        int          k;
        rst = 1'b0;
        valid_i = 1'b0;
        stall_i = 1'b0;
        opecode = OPC_ADD;
        data_rd = '0;
        data_rs = '0;
        #12;
        chk("rst_valid", 64'(valid_o), 64'(0));
        chk("rst_data", 64'(data_o), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_stall", 64'(stall_o), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        do_op(OPC_MUL, 32'd7, 32'd6);            consume();
        do_op(OPC_MUL, 32'hFFFF_FFFF, 32'd2);    consume();
        do_op(OPC_DIV, 32'd100, 32'd7);          consume();
        do_op(OPC_DIV, 32'd5, 32'd0);            consume();

        stall_i = 1'b1;
        do_op(OPC_MUL, 32'd12345, 32'd678);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("hold_data", 64'(data_o), 64'(32'd8369910));
            chk("hold_valid", 64'(valid_o), 64'(1));
            chk("hold_stall", 64'(stall_o), 64'(1));
        end
        stall_i = 1'b0;
        do_op(OPC_MUL, 32'd3, 32'd3);
        consume();

        @(negedge clk);
        valid_i = 1'b1;
        opecode = OPC_DIV;
        data_rd = 32'd1000;
        data_rs = 32'd3;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_valid", 64'(valid_o), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_stall", 64'(stall_o), 64'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (LAT + 4) begin
            @(posedge clk);
            #1;
            chk("abort_no_result", 64'(valid_o), 64'(0));
        end
        do_op(OPC_MUL, 32'd2, 32'd2);
        consume();

        @(negedge clk);
        valid_i = 1'b1;
        opecode = OPC_ADD;
        data_rd = 32'd5;
        data_rs = 32'd6;
        #1;
        chk("add_stall", 64'(stall_o), 64'(0));
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("add_busy", 64'(busy), 64'(0));
            chk("add_valid", 64'(valid_o), 64'(0));
        end
        valid_i = 1'b0;

        for (int i = 0; i < 24; i++) begin
            ropc = ($urandom_range(0, 1) == 0) ? OPC_MUL : OPC_DIV;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            rexp = ref_result(ropc == OPC_DIV, ra, rb);
            k = $urandom_range(0, 3);
            stall_i = (k != 0);
            do_op(ropc, ra, rb);
            repeat (k) begin
                @(posedge clk);
                #1;
                chk("rand_hold", 64'(data_o), 64'(rexp));
            end
            stall_i = 1'b0;
            consume();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
